// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetch FSM between instruction memory and decoder
//   clk, rst (sync, active-low)
//   imem_req/imem_addr -> memory read request; imem_ready/imem_rdata <- completion and data
//   inst_valid/inst/inst_pc -> decoder handoff; dec_ready <- decoder consumes
//   redirect_valid/redirect_target <- control-flow redirect
//   fetch_err -> sticky misaligned-redirect error; inst_count -> instructions handed off
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        dec_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_err,
  output logic [31:0] inst_count
);
  typedef enum logic [2:0] {IDLE, FETCH, KILL, HOLD, HALT} state_t;
  state_t      state;
  logic [31:0] pc, req_addr;
  logic        bad;
  assign bad       = redirect_valid && redirect_target[1:0] != 2'b00;
  assign imem_addr = req_addr;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      fetch_err  <= 1'b0;
      inst_count <= '0;
    end else if (bad && state != HALT) begin
      fetch_err  <= 1'b1;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      state      <= HALT;
    end else begin
      case (state)
        IDLE: begin
          imem_req <= 1'b1;
          state    <= FETCH;
          req_addr <= redirect_valid ? redirect_target : pc;
          if (redirect_valid) pc <= redirect_target;
        end
        FETCH: begin
          if (redirect_valid) begin
            pc <= redirect_target;
            if (imem_ready) req_addr <= redirect_target;
            else state <= KILL;
          end else if (imem_ready) begin
            inst       <= imem_rdata;
            inst_pc    <= req_addr;
            inst_valid <= 1'b1;
            pc         <= req_addr + 32'd4;
            imem_req   <= 1'b0;
            state      <= HOLD;
          end
        end
        KILL: begin
          // the stale request must still complete; its data is dropped
          if (redirect_valid) pc <= redirect_target;
          if (imem_ready) begin
            req_addr <= redirect_valid ? redirect_target : pc;
            state    <= FETCH;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            inst_valid <= 1'b0;
            pc         <= redirect_target;
            req_addr   <= redirect_target;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end else if (dec_ready) begin
            inst_valid <= 1'b0;
            inst_count <= inst_count + 32'd1;
            req_addr   <= pc;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
